res_mem_reader: RTL and testbench

- Drain engine for the result memory: on `start`, it reads `wordCount` consecutive words beginning at `baseAddr`.
- The memory's read port returns words byte-swapped; this block restores the original byte order.
- Restored words are streamed out on a valid/ready interface.
- It sits between the result memory and the host/output stage, which consumes final results after compute completes.

---
 rtl/res_mem_reader_if.sv | 28 ++
 rtl/res_mem_reader.sv | 113 +++++++++++
 tb/tb_res_mem_reader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/res_mem_reader_if.sv
// Bundles the drain-control, memory-read and output-stream signals of res_mem_reader.
// slave is the reader's view; master is the view of its environment.
interface res_mem_reader_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [31:0]       baseAddr;
  logic [CNT_W-1:0]  wordCount;
  logic              memREn;
  logic [31:0]       memAddr;
  logic [DATA_W-1:0] memData;
  logic [DATA_W-1:0] outData;
  logic              outValid;
  logic              outReady;
  logic              busy;
  logic              done;

  modport slave (
    input  start, baseAddr, wordCount, memData, outReady,
    output memREn, memAddr, outData, outValid, busy, done
  );

  modport master (
    output start, baseAddr, wordCount, memData, outReady,
    input  memREn, memAddr, outData, outValid, busy, done
  );
endinterface

// File: rtl/res_mem_reader.sv
// Drains wordCount consecutive words from the result memory starting at baseAddr,
// undoes the read port's byte swap and streams the words out through a 2-entry FIFO.
module res_mem_reader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rstN,
  res_mem_reader_if.slave  bus
);
  // DEPTH is a power of two, so address wrap is plain truncation to AW bits
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            r_state, w_nextState;
  logic [AW-1:0]     r_base, r_lastAddr, w_addr;
  logic [CNT_W-1:0]  r_count, r_issued, r_popped;
  logic [DATA_W-1:0] r_head, r_tail, w_pushData;
  logic [1:0]        r_occ;
  logic              w_issue, w_pop;
  logic              w_unusedBase;

  function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 8; i++) begin
      r[8*i +: 8] = w[DATA_W-8-8*i +: 8];
    end
    return r;
  endfunction

  // Only the low AW address bits select a word
  assign w_unusedBase = ^bus.baseAddr[31:AW];

  assign w_addr     = r_base + r_issued[AW-1:0];
  assign w_pushData = byte_rev(bus.memData);
  assign w_pop      = (r_occ != 2'd0) && bus.outReady;

  always_comb begin
    w_nextState = r_state;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_nextState = (bus.wordCount == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        // A slot is free next edge if the FIFO is not full or its head leaves now
        w_issue = (r_issued < r_count) && ((r_occ < 2'd2) || w_pop);
        if ((r_issued == r_count) && (r_popped == r_count)) begin
          w_nextState = FIN;
        end
      end
      FIN:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign bus.memREn   = w_issue;
  assign bus.memAddr  = 32'(w_issue ? w_addr : r_lastAddr);
  assign bus.outValid = (r_occ != 2'd0);
  assign bus.outData  = r_head;
  assign bus.busy     = (r_state == RUN) || (r_state == FIN);
  assign bus.done     = (r_state == FIN);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state    <= IDLE;
      r_occ      <= 2'd0;
      r_issued   <= '0;
      r_popped   <= '0;
      r_lastAddr <= '0;
      r_head     <= '0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == IDLE) && bus.start) begin
        r_base   <= bus.baseAddr[AW-1:0];
        r_count  <= bus.wordCount;
        r_issued <= '0;
        r_popped <= '0;
      end
      if (w_issue) begin
        r_issued   <= r_issued + 1'b1;
        r_lastAddr <= w_addr;
      end
      if (w_pop) begin
        r_popped <= r_popped + 1'b1;
      end
      case ({w_issue, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= w_pushData;
          else               r_tail <= w_pushData;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= w_pushData;
          end else begin
            r_head <= r_tail;
            r_tail <= w_pushData;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_res_mem_reader.sv
// Randomised scoreboard bench for res_mem_reader: stimulus queues expected words and
// addresses from a plain memory array; a negedge monitor compares whatever the DUT presents.
module tb_res_mem_reader;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;
  localparam int CNT_W  = 8;
  localparam int AW     = 7;

  logic clk = 1'b0;
  logic rstN;

  res_mem_reader_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  res_mem_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] orig [DEPTH];

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // The memory read port presents every stored word byte-swapped
  assign bus.memData = bswap(orig[bus.memAddr[AW-1:0]]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];
  int addr_q [$];
  int mren_tot = 0, pop_tot = 0, done_cnt = 0, busy_cnt = 0;
  int last_pop_cyc = 0, start_cyc = 0, cur_cnt = 0;
  bit first_ren = 0, first_val = 0, hold_prev = 0;
  logic [31:0] prev_data;
  int rmode = 0, rcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rcnt++;
    case (rmode)
      0:       bus.outReady = 1'b1;
      1:       bus.outReady = ((rcnt % 3) == 0);
      default: bus.outReady = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rstN === 1'b1) begin
        int occ;
        occ = mren_tot - pop_tot;
        checks++;
        if (occ < 0 || occ > 2) begin
          errors++;
          $display("FAIL fifo_occ: got %0d expected 0..2", occ);
        end
        chk("outValid", bus.outValid, occ != 0);
        if (hold_prev) begin
          chk("hold_valid", bus.outValid, 1);
          chk("hold_data", bus.outData, prev_data);
        end
        if (bus.outValid && first_val) begin
          chk("valid_latency", cyc - start_cyc, 2);
          first_val = 0;
        end
        if (bus.memREn) begin
          if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_read: got addr %0d expected no read", bus.memAddr);
          end else begin
            chk("memAddr", bus.memAddr, addr_q.pop_front());
          end
          if (first_ren) begin
            chk("ren_latency", cyc - start_cyc, 1);
            first_ren = 0;
          end
          mren_tot++;
        end
        if (bus.outValid && bus.outReady) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got %0h expected none", bus.outData);
          end else begin
            chk("outData", bus.outData, exp_q.pop_front());
          end
          pop_tot++;
          last_pop_cyc = cyc;
        end
        if (bus.done) begin
          done_cnt++;
          chk("done_time", cyc, (cur_cnt == 0) ? start_cyc + 1 : last_pop_cyc + 2);
        end
        if (bus.busy) busy_cnt++;
        hold_prev = bus.outValid && !bus.outReady;
        prev_data = bus.outData;
      end
    end
  endtask

  task automatic launch(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      addr_q.push_back((base + i) % DEPTH);
      exp_q.push_back(orig[(base + i) % DEPTH]);
    end
    cur_cnt       = cnt;
    bus.baseAddr  = base;
    bus.wordCount = cnt[CNT_W-1:0];
    bus.start     = 1'b1;
    start_cyc     = cyc;
    first_ren     = (cnt != 0);
    first_val     = (cnt != 0);
    step();
    bus.start = 1'b0;
  endtask

  task automatic drain(input int base, input int cnt, input int mode, input bit pulse);
    int d0, m0, b0, budget;
    d0 = done_cnt;
    m0 = mren_tot;
    b0 = busy_cnt;
    rmode = mode;
    launch(base, cnt);
    budget = cnt * 6 + 20;
    for (int k = 0; k < budget && done_cnt == d0; k++) begin
      if (pulse && cnt >= 4 && k == 1) begin
        bus.start     = 1'b1;
        bus.baseAddr  = 50;
        bus.wordCount = 3;
      end else begin
        bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got no done expected done within %0d cycles", budget);
    end
    repeat (3) step();
    chk("done_count", done_cnt - d0, 1);
    chk("read_count", mren_tot - m0, cnt);
    chk("words_left", exp_q.size(), 0);
    chk("addrs_left", addr_q.size(), 0);
    chk("busy_idle", bus.busy, 0);
    if (cnt == 0) chk("busy_cycles", busy_cnt - b0, 1);
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic abort_test();
    int p0, d0;
    rmode = 0;
    p0 = pop_tot;
    launch(20, 5);
    for (int k = 0; k < 40 && (pop_tot - p0) < 2; k++) step();
    if ((pop_tot - p0) < 2) begin
      checks++;
      errors++;
      $display("FAIL abort_wait: got %0d pops expected 2", pop_tot - p0);
    end
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    chk("abort_outValid", bus.outValid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    exp_q.delete();
    addr_q.delete();
    mren_tot  = 0;
    pop_tot   = 0;
    hold_prev = 0;
    first_ren = 0;
    first_val = 0;
    d0 = done_cnt;
    repeat (3) step();
    chk("abort_no_done", done_cnt - d0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) orig[i] = $urandom;
    orig[4] = 32'h44332211;
    orig[5] = 32'h88776655;
    orig[6] = 32'hCCBBAA99;
    orig[7] = 32'h00FFEEDD;
    bus.start     = 1'b0;
    bus.baseAddr  = '0;
    bus.wordCount = '0;
    bus.outReady  = 1'b0;
    rstN = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) step();
    chk("rst_memREn", bus.memREn, 0);
    chk("rst_memAddr", bus.memAddr, 0);
    chk("rst_outValid", bus.outValid, 0);
    chk("rst_outData", bus.outData, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rstN = 1'b1;
    step();

    drain(4, 4, 0, 0);
    drain(4, 0, 0, 0);
    drain(126, 4, 0, 0);
    drain(10, 6, 1, 0);
    abort_test();
    drain(0, 1, 0, 0);
    drain(30, 8, 0, 1);
    drain(60, 7, 2, 1);
    for (int t = 0; t < 12; t++) begin
      drain($urandom_range(0, DEPTH - 1), $urandom_range(0, 12), 2, 0);
    end
    drain(100, 130, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
